// File: rtl/uart_tx_if.sv
// Handshake bundle between a byte producer and the UART transmitter.
// The producer side uses the master modport and the transmitter uses the slave modport.
interface uart_tx_if #(
    parameter int SIZEDATA = 8
);
    logic                i_tick;
    logic                i_tx_start;
    logic [SIZEDATA-1:0] i_tx_data;
    logic                o_tx;
    logic                o_tx_done;
    logic                o_tx_busy;

    modport slave (
        input  i_tick,
        input  i_tx_start,
        input  i_tx_data,
        output o_tx,
        output o_tx_done,
        output o_tx_busy
    );

    modport master (
        output i_tick,
        output i_tx_start,
        output i_tx_data,
        input  o_tx,
        input  o_tx_done,
        input  o_tx_busy
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, SIZEDATA data bits sent LSB first, then a stop period of SB_TICKS ticks.
// Every output comes straight from a flop, so the serial line cannot glitch.
module uart_tx #(
    parameter int SIZEDATA   = 8,
    parameter int SB_TICKS   = 16,
    parameter int OVERSAMPLE = 16
) (
    input  logic      i_clock,
    input  logic      i_reset,
    uart_tx_if.slave  bus
);
    localparam int TICK_MAX = (OVERSAMPLE > SB_TICKS) ? OVERSAMPLE : SB_TICKS;
    localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
    localparam int BIT_W    = (SIZEDATA > 1) ? $clog2(SIZEDATA) : 1;

    localparam logic [TICK_W-1:0] OS_LAST  = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] SB_LAST  = TICK_W'(SB_TICKS - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(SIZEDATA - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e              state_q;
    logic [TICK_W-1:0]   tick_q;
    logic [BIT_W-1:0]    bit_q;
    logic [SIZEDATA-1:0] shreg_q;
    logic [SIZEDATA-1:0] shreg_d;
    logic                tx_q;
    logic                done_q;
    logic                busy_q;

    // Shift register contents after moving to the next data bit.
    always_comb begin
        shreg_d = shreg_q >> 32'd1;
    end

    // Frame sequencer; a request in the done cycle is ignored because done_q is still set.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (bus.i_tx_start && !done_q) begin
                        shreg_q <= bus.i_tx_data;
                        tick_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= START;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                START: begin
                    if (bus.i_tick) begin
                        if (tick_q == OS_LAST) begin
                            tick_q  <= '0;
                            tx_q    <= shreg_q[0];
                            state_q <= DATA;
                        end else begin
                            tick_q <= tick_q + TICK_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (bus.i_tick) begin
                        if (tick_q == OS_LAST) begin
                            tick_q  <= '0;
                            shreg_q <= shreg_d;
                            if (bit_q == BIT_LAST) begin
                                bit_q   <= '0;
                                tx_q    <= 1'b1;
                                state_q <= STOP;
                            end else begin
                                bit_q <= bit_q + BIT_W'(1);
                                tx_q  <= shreg_d[0];
                            end
                        end else begin
                            tick_q <= tick_q + TICK_W'(1);
                        end
                    end
                end
                STOP: begin
                    if (bus.i_tick) begin
                        if (tick_q == SB_LAST) begin
                            tick_q  <= '0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            tick_q <= tick_q + TICK_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tick_q  <= '0;
                    bit_q   <= '0;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_tx      = tx_q;
    assign bus.o_tx_done = done_q;
    assign bus.o_tx_busy = busy_q;
endmodule
